// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and helpers for the UART transmit arbiter:
//                state encoding, owner-ID header tag, one-hot conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

   // Widest requester vector the helpers support
   localparam int c_MAX_REQ = 16;

   // Upper nibble of the owner-ID header byte
   localparam logic [3:0] c_HDR_TAG = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_XFER = 2'd2
   } arb_state_t;

   // Index to one-hot over the widest supported vector
   function automatic logic [c_MAX_REQ-1:0] idx_to_onehot(input logic [3:0] idx);
      logic [c_MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational rotated-priority picker. Searches upward from
//                pointer+1 with wrap-around and returns the first requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int P_REQ_NUM = 4,
   parameter int P_IDX_W   = $clog2(P_REQ_NUM)
) (
   input  logic [P_REQ_NUM-1:0] i_req,
   input  logic [P_IDX_W-1:0]   i_ptr,
   output logic [P_REQ_NUM-1:0] o_onehot,
   output logic [P_IDX_W-1:0]   o_idx
);

   logic                 w_found;
   logic [P_IDX_W-1:0]   w_pos;
   logic [c_MAX_REQ-1:0] w_oh_full;

   // First requesting index after the pointer, wrapping at P_REQ_NUM
   always_comb begin
      w_found = 1'b0;
      w_pos   = '0;
      o_idx   = '0;
      for (int i = 1; i <= P_REQ_NUM; i++) begin
         w_pos = P_IDX_W'((int'(i_ptr) + i) % P_REQ_NUM);
         if (!w_found && i_req[w_pos]) begin
            w_found = 1'b1;
            o_idx   = w_pos;
         end
      end
   end

   assign w_oh_full = idx_to_onehot(4'(o_idx));
   assign o_onehot  = w_found ? w_oh_full[P_REQ_NUM-1:0] : '0;

   generate
      if (P_REQ_NUM < c_MAX_REQ) begin : g_oh_spare
         logic w_unused_oh;
         assign w_unused_oh = |w_oh_full[c_MAX_REQ-1:P_REQ_NUM];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Round-robin, packet-locked arbiter sharing one UART
//                transmitter. Grant is held from first byte to last byte,
//                then priority rotates past the finished owner. A watchdog
//                releases an owner that goes quiet mid-packet.
//                Optional build macro UART_TX_ARB_ID_EN prefixes each packet
//                with an owner-ID header byte (0xA0 | owner).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
   import uart_arb_pkg::*;
#(
   parameter int P_REQ_NUM    = 4,
   parameter int P_DATA_WIDTH = 8,
   parameter int P_TIMEOUT    = 1023
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data,
   input  logic [P_REQ_NUM-1:0]              i_req_valid,
   input  logic [P_REQ_NUM-1:0]              i_req_last,
   output logic [P_REQ_NUM-1:0]              o_req_ready,
   output logic [P_DATA_WIDTH-1:0]           o_uart_tx_data,
   output logic                              o_uart_tx_valid,
   input  logic                              i_uart_tx_ready,
   output logic [P_REQ_NUM-1:0]              o_grant,
   output logic                              o_busy,
   output logic                              o_timeout
);

   localparam int c_IDX_W  = $clog2(P_REQ_NUM);
   localparam int c_WD_W   = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
   localparam int c_WD_LIM = (P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0;
   localparam bit c_WD_EN  = (P_TIMEOUT != 0);

   arb_state_t             r_state;
   logic [P_REQ_NUM-1:0]   r_grant;
   logic [c_IDX_W-1:0]     r_gidx;
   logic [c_IDX_W-1:0]     r_ptr;
   logic [c_WD_W-1:0]      r_wd;
   logic                   r_busy;
   logic                   r_timeout;

   logic [P_REQ_NUM-1:0]   w_pick_oh;
   logic [c_IDX_W-1:0]     w_pick_idx;
   logic [P_DATA_WIDTH-1:0] w_g_data;
   logic                   w_g_valid;
   logic                   w_g_last;
   logic                   w_wd_expire;

   uart_rr_pick #(
      .P_REQ_NUM (P_REQ_NUM),
      .P_IDX_W   (c_IDX_W)
   ) u_pick (
      .i_req    (i_req_valid),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx)
   );

   assign w_g_data    = i_req_data[int'(r_gidx)*P_DATA_WIDTH +: P_DATA_WIDTH];
   assign w_g_valid   = i_req_valid[r_gidx];
   assign w_g_last    = i_req_last[r_gidx];
   assign w_wd_expire = c_WD_EN && (r_wd == c_WD_W'(c_WD_LIM));

   assign o_grant   = r_grant;
   assign o_busy    = r_busy;
   assign o_timeout = r_timeout;

   // Downstream mux driven from the registered owner; silent while idle
   always_comb begin
      o_uart_tx_valid = 1'b0;
      o_uart_tx_data  = '0;
      o_req_ready     = '0;
      case (r_state)
         ST_XFER: begin
            o_uart_tx_valid = w_g_valid;
            o_uart_tx_data  = w_g_data;
            o_req_ready     = r_grant & {P_REQ_NUM{i_uart_tx_ready}};
         end
`ifdef UART_TX_ARB_ID_EN
         ST_HDR: begin
            o_uart_tx_valid = 1'b1;
            o_uart_tx_data  = P_DATA_WIDTH'({c_HDR_TAG, 4'(r_gidx)});
         end
`endif
         default: ;
      endcase
   end

   // Arbitration FSM, packet lock, priority rotation and watchdog
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_gidx    <= '0;
         r_ptr     <= c_IDX_W'(P_REQ_NUM - 1);
         r_wd      <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|i_req_valid) begin
                  r_grant <= w_pick_oh;
                  r_gidx  <= w_pick_idx;
                  r_busy  <= 1'b1;
                  r_wd    <= '0;
`ifdef UART_TX_ARB_ID_EN
                  r_state <= ST_HDR;
`else
                  r_state <= ST_XFER;
`endif
               end
            end
            ST_HDR: begin
               if (i_uart_tx_ready) begin
                  r_state <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_g_valid) begin
                  r_wd <= '0;
                  if (i_uart_tx_ready && w_g_last) begin
                     r_state <= ST_IDLE;
                     r_ptr   <= r_gidx;
                     r_grant <= '0;
                     r_busy  <= 1'b0;
                  end
               end else if (w_wd_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
                  r_ptr     <= r_gidx;
                  r_grant   <= '0;
                  r_busy    <= 1'b0;
               end else if (r_wd != '1) begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Self-checking bench for uart_tx_arb. Per-requester byte
//                queues feed the DUT; a packet-level reference (owner,
//                rotating pointer, idle count) predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 8;
`ifdef UART_TX_ARB_ID_EN
   localparam int ID = 1;
`else
   localparam int ID = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [W-1:0]   tx_data;
   logic           tx_valid, tx_ready, busy, tmo;

   always #5 clk = ~clk;

   uart_tx_arb #(.P_REQ_NUM(N), .P_DATA_WIDTH(W), .P_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_data(req_data), .i_req_valid(req_valid), .i_req_last(req_last),
      .o_req_ready(req_ready),
      .o_uart_tx_data(tx_data), .o_uart_tx_valid(tx_valid), .i_uart_tx_ready(tx_ready),
      .o_grant(grant), .o_busy(busy), .o_timeout(tmo)
   );

   int errors = 0;
   int checks = 0;

   // Producers: {last, byte} per entry
   logic [8:0] q [N][$];
   logic [N-1:0] en;

   // Reference: current owner (-1 idle), rotation pointer, quiet-cycle count
   int m_own, m_ptr, m_wd;
   bit m_hdr, m_to;

   // Observation logs for the directed scenarios
   logic [N-1:0] gh[$];
   logic [7:0]   line[$];
   int           acc_own[$];
   logic [7:0]   acc_byte[$];
   int           acc_t[$];
   int           to_t[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own = -1; m_ptr = N - 1; m_wd = 0; m_hdr = 0; m_to = 0;
   endtask

   task automatic clear_logs();
      gh.delete(); line.delete(); acc_own.delete(); acc_byte.delete();
      acc_t.delete(); to_t.delete();
   endtask

   task automatic drive();
      logic [8:0] e;
      for (int k = 0; k < N; k++) begin
         if (q[k].size() > 0 && en[k]) begin
            e = q[k][0];
            req_valid[k]       = 1'b1;
            req_data[k*W +: W] = e[7:0];
            req_last[k]        = e[8];
         end else begin
            req_valid[k]       = 1'b0;
            req_data[k*W +: W] = 8'($urandom);
            req_last[k]        = 1'($urandom);
         end
      end
   endtask

   // Check one cycle at the falling edge, then advance reference and queues
   task automatic step();
      logic [N-1:0] eg, er;
      logic         ev;
      logic [7:0]   ed;
      int           o, c;
      bit           hit;
      @(negedge clk);
      eg = '0; er = '0; ev = 1'b0; ed = '0;
      if (m_own >= 0) begin
         eg[m_own] = 1'b1;
         if (m_hdr) begin
            ev = 1'b1;
            ed = 8'hA0 | 8'(m_own);
         end else begin
            ev         = req_valid[m_own];
            ed         = req_data[m_own*W +: W];
            er[m_own]  = tx_ready;
         end
      end
      chk("grant", grant, eg);
      chk("busy", busy, m_own >= 0);
      chk("timeout", tmo, m_to);
      chk("tx_valid", tx_valid, ev);
      chk("tx_data", tx_data, ed);
      chk("req_ready", req_ready, er);

      gh.push_back(grant);
      if (tx_valid && tx_ready) line.push_back(tx_data);
      for (int k = 0; k < N; k++)
         if (req_ready[k] && req_valid[k]) begin
            acc_own.push_back(k);
            acc_byte.push_back(req_data[k*W +: W]);
            acc_t.push_back(gh.size() - 1);
         end
      if (tmo) to_t.push_back(gh.size() - 1);

      o    = m_own;
      m_to = 0;
      if (o < 0) begin
         if (req_valid != '0) begin
            hit = 0;
            for (int i = 1; i <= N; i++) begin
               c = (m_ptr + i) % N;
               if (!hit && req_valid[c]) begin m_own = c; hit = 1; end
            end
            m_hdr = (ID != 0);
            m_wd  = 0;
         end
      end else if (m_hdr) begin
         if (tx_ready) m_hdr = 0;
      end else if (req_valid[o]) begin
         m_wd = 0;
         if (tx_ready) begin
            void'(q[o].pop_front());
            if (req_last[o]) begin m_ptr = o; m_own = -1; end
         end
      end else if (m_wd == TO - 1) begin
         m_to = 1; m_ptr = o; m_own = -1;
      end else begin
         m_wd++;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         step();
      end
   endtask

   initial begin
      int cnt, first;
      rst_n = 1'b1; en = '1; tx_ready = 1'b1;
      req_data = '0; req_valid = '0; req_last = '0;
      model_reset();

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: req0 three-byte packet
      clear_logs();
      q[0].push_back({1'b0, 8'h11}); q[0].push_back({1'b0, 8'h22}); q[0].push_back({1'b1, 8'h33});
      run(8);
      cnt = 0;
      foreach (gh[i]) if (gh[i] === 4'b0001) cnt++;
      chk("t1_grant_cycles", cnt, 3 + ID);
      chk("t1_nbytes", acc_byte.size(), 3);
      if (acc_byte.size() == 3) begin
         chk("t1_b0", acc_byte[0], 8'h11);
         chk("t1_b1", acc_byte[1], 8'h22);
         chk("t1_b2", acc_byte[2], 8'h33);
      end
      chk("t1_grant_end", grant, 0);

      // 2: req1/req2 single-byte packets alternate
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         q[1].push_back({1'b1, 8'h5A});
         q[2].push_back({1'b1, 8'hA5});
      end
      run(22);
      chk("t2_npkts", acc_own.size(), 6);
      if (acc_own.size() == 6)
         for (int i = 0; i < 6; i++) begin
            chk("t2_owner", acc_own[i], (i % 2 == 0) ? 1 : 2);
            chk("t2_byte", acc_byte[i], (i % 2 == 0) ? 8'h5A : 8'hA5);
         end

      // 3: downstream stall does not trip the watchdog
      clear_logs();
      q[3].push_back({1'b0, 8'h3C}); q[3].push_back({1'b1, 8'hC3});
      tx_ready = 1'b0;
      run(50);
      chk("t3_no_timeout", to_t.size(), 0);
      chk("t3_hold", tx_data, (ID != 0) ? 8'hA3 : 8'h3C);
      tx_ready = 1'b1;
      run(8);
      chk("t3_nbytes", acc_byte.size(), 2);
      if (acc_byte.size() == 2) begin
         chk("t3_b0", acc_byte[0], 8'h3C);
         chk("t3_b1", acc_byte[1], 8'hC3);
      end

      // 4: watchdog releases a quiet owner; waiting req1 follows
      clear_logs();
      q[0].push_back({1'b0, 8'h44});
      q[1].push_back({1'b1, 8'h77});
      run(18);
      chk("t4_to_count", to_t.size(), 1);
      if (to_t.size() > 0 && acc_t.size() > 0) begin
         chk("t4_delay_after_drop", to_t[0] - (acc_t[0] + 1), 8);
         chk("t4_grant_at_to", gh[to_t[0]], 0);
         chk("t4_next_grant", gh[to_t[0] + 1], 4'b0010);
      end
      chk("t4_nbytes", acc_byte.size(), 2);
      if (acc_byte.size() == 2) chk("t4_req1_byte", acc_byte[1], 8'h77);

      // 5: line view of a req2 single-byte packet
      clear_logs();
      q[2].push_back({1'b1, 8'h7E});
      run(6);
      chk("t5_line_len", line.size(), 1 + ID);
      if (line.size() == 1 + ID) begin
         if (ID != 0) chk("t5_hdr", line[0], 8'hA2);
         chk("t5_payload", line[ID], 8'h7E);
      end

      // 6: reset mid-packet, then req0 wins over req1
      clear_logs();
      q[1].push_back({1'b0, 8'h61}); q[1].push_back({1'b0, 8'h62}); q[1].push_back({1'b1, 8'h63});
      run(3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", tx_valid, 0);
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_busy", busy, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
      q[0].push_back({1'b1, 8'h0F});
      run(10);
      first = 0;
      foreach (gh[i]) if (first == 0 && gh[i] !== 4'b0000) first = int'(gh[i]);
      chk("t6_first_grant", first, 1);

      // Random traffic against the reference
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < N; k++) begin
            if (q[k].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) q[k].push_back({(b == len - 1), 8'($urandom)});
            end
            en[k] = ($urandom_range(0, 7) != 0);
         end
         tx_ready = ($urandom_range(0, 3) != 0);
         drive();
         step();
      end
      en = '1; tx_ready = 1'b1;
      run(60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
